// File: rtl/cpu_trace_buffer.sv
// Trigger-qualified trace buffer for CPU ALU activity: records {A, B, flags} samples
// around a flag-pattern trigger into a circular buffer, then drains them oldest-first.
module cpu_trace_buffer #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATA_W-1:0]          A,
    input  logic [DATA_W-1:0]          B,
    input  logic [3:0]                 FLAGS,
    input  logic                       SAMPLE_EN,
    input  logic                       ARM,
    input  logic [3:0]                 TRIG_MASK,
    input  logic [3:0]                 TRIG_VAL,
    input  logic                       RD_EN,
    output logic [2*DATA_W+3:0]        RD_DATA,
    output logic                       RD_VALID,
    output logic [1:0]                 STATE,
    output logic [$clog2(DEPTH):0]     COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * DATA_W + 4;
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRE_C     = (AW+1)'(PRE_TRIG);
    localparam logic [AW:0] POST_LOAD = (AW+1)'(DEPTH - PRE_TRIG - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [AW:0]     count_q, count_d;
    logic [AW:0]     post_q, post_d;
    logic [EW-1:0]   rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;

    logic [EW-1:0]   mem [DEPTH];
    logic            we;
    logic [EW-1:0]   wdata;
    logic            flag_hit;
    logic [AW:0]     count_inc;

    assign wdata     = {A, B, FLAGS};
    assign flag_hit  = ((FLAGS & TRIG_MASK) == (TRIG_VAL & TRIG_MASK));
    assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d    = state_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        post_d     = post_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        we         = 1'b0;

        if (ARM) begin
            state_d = S_ARMED;
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            post_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ARMED: begin
                    if (SAMPLE_EN) begin
                        we      = 1'b1;
                        wp_d    = wp_q + 1'b1;
                        count_d = count_inc;
                        // count_q is the depth of history before this sample
                        if (flag_hit && count_q >= PRE_C) begin
                            if (POST_LOAD == '0) begin
                                state_d = S_DONE;
                                rp_d    = wp_q + 1'b1;
                                count_d = DEPTH_C;
                            end else begin
                                state_d = S_POST;
                                post_d  = POST_LOAD;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (SAMPLE_EN) begin
                        we      = 1'b1;
                        wp_d    = wp_q + 1'b1;
                        count_d = count_inc;
                        post_d  = post_q - 1'b1;
                        if (post_q == 1) begin
                            state_d = S_DONE;
                            rp_d    = wp_q + 1'b1;
                            count_d = DEPTH_C;
                        end
                    end
                end
                S_DONE: begin
                    if (RD_EN && count_q != '0) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem[rp_q];
                        rp_d       = rp_q + 1'b1;
                        count_d    = count_q - 1'b1;
                        if (count_q == 1) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            post_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            post_q     <= post_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // NOTE: storage array has no reset; COUNT/state guard against reading stale entries.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wp_q] <= wdata;
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign STATE    = state_q;
    assign COUNT    = count_q;

endmodule
